// File: rtl/cskipa_pkg.sv
// Shared constants, state encoding and sizing helpers for the sequential carry-skip adder.
package cskipa_pkg;

  localparam int SLICE_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int chunk_count(input int width);
    return width / SLICE_W;
  endfunction

  // The chunk counter must be at least one bit wide, even for a single-chunk build.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cskipa_seq_ctrl_if.sv
// Operand/result handshake bundle for cskipa_seq_ctrl.
// When CSKIPA_SEQ_SUB_EN is defined, the bundle also carries the i_sub request bit.
interface cskipa_seq_ctrl_if #(
  parameter int WIDTH = 24
) ();

  logic             i_valid;
  logic             ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             i_cin;
`ifdef CSKIPA_SEQ_SUB_EN
  logic             i_sub;
`endif
  logic             valid_out;
  logic             i_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef CSKIPA_SEQ_SUB_EN
  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_sub, i_ready,
    input  ready, valid_out, sum, cout
  );

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_sub, i_ready,
    output ready, valid_out, sum, cout
  );
`else
  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_ready,
    input  ready, valid_out, sum, cout
  );

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_ready,
    output ready, valid_out, sum, cout
  );
`endif

endinterface

// File: rtl/cskipa_slice6.sv
// Combinational 6-bit carry-skip slice: two 3-bit ripple groups, each of which
// forwards its own carry-in when every bit in the group propagates.
module cskipa_slice6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] s,
  output logic       co
);

  logic [5:0] p;
  logic [5:0] g;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic       c5;
  logic       lo_ripple;
  logic       hi_ripple;

  assign p = a ^ b;
  assign g = a & b;

  assign c1        = g[0] | (p[0] & cin);
  assign c2        = g[1] | (p[1] & c1);
  assign lo_ripple = g[2] | (p[2] & c2);
  assign c3        = (&p[2:0]) ? cin : lo_ripple;

  assign c4        = g[3] | (p[3] & c3);
  assign c5        = g[4] | (p[4] & c4);
  assign hi_ripple = g[5] | (p[5] & c5);
  assign co        = (&p[5:3]) ? c3 : hi_ripple;

  assign s = p ^ {c5, c4, c3, c2, c1, cin};

endmodule

// File: rtl/cskipa_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one 6-bit carry-skip slice, LSB chunk first.
// Defining CSKIPA_SEQ_SUB_EN adds subtraction selected by i_sub at accept time.
module cskipa_seq_ctrl
  import cskipa_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  cskipa_seq_ctrl_if.slave bus
);

  localparam int N     = chunk_count(WIDTH);
  localparam int CNT_W = cnt_width(N);

  generate
    if (WIDTH <= 0 || (WIDTH % SLICE_W) != 0) begin : g_width_check
      $error("cskipa_seq_ctrl: WIDTH must be a positive multiple of 6");
    end
  endgenerate

  state_t                      state_q;
  state_t                      state_d;
  logic [CNT_W-1:0]            k_q;
  logic                        carry_q;
  logic [N-1:0][SLICE_W-1:0]   op_a_q;
  logic [N-1:0][SLICE_W-1:0]   op_b_q;
  logic [N-1:0][SLICE_W-1:0]   sum_q;
  logic                        cout_q;
  logic                        accept;
  logic                        last_chunk;
  logic                        ready_d;
  logic                        valid_d;
  logic [WIDTH-1:0]            op_b_in;
  logic                        carry_in;
  logic [SLICE_W-1:0]          slice_s;
  logic                        slice_co;

  // Subtraction stores the inverted B operand and forces a carry-in of one.
`ifdef CSKIPA_SEQ_SUB_EN
  assign op_b_in  = bus.i_sub ? ~bus.i_add_term2 : bus.i_add_term2;
  assign carry_in = bus.i_sub ? 1'b1 : bus.i_cin;
`else
  assign op_b_in  = bus.i_add_term2;
  assign carry_in = bus.i_cin;
`endif

  assign last_chunk = (k_q == CNT_W'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    valid_d = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.i_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Each RUN edge retires one chunk; the inter-chunk carry lives in carry_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      op_a_q  <= bus.i_add_term1;
      op_b_q  <= op_b_in;
      carry_q <= carry_in;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      sum_q[k_q] <= slice_s;
      carry_q    <= slice_co;
      k_q        <= k_q + 1'b1;
      if (last_chunk) begin
        cout_q <= slice_co;
      end
    end
  end

  cskipa_slice6 u_slice (
    .a   (op_a_q[k_q]),
    .b   (op_b_q[k_q]),
    .cin (carry_q),
    .s   (slice_s),
    .co  (slice_co)
  );

  assign bus.ready     = ready_d;
  assign bus.valid_out = valid_d;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: doc/cskipa_seq_ctrl.md
# cskipa_seq_ctrl

Multi-cycle sequencer that computes a WIDTH-bit addition by driving a single 6-bit carry-skip adder slice once per cycle, least-significant chunk first. It holds the inter-chunk carry in a register. It sits between an operand producer and a result consumer and uses valid/ready handshakes on both sides. It trades latency for area against a full-width carry-skip adder in the adder-evaluation datapath.

## Interface
Parameters:
- WIDTH, 24: operand and sum width; must be a positive multiple of 6 (elaboration error otherwise).

Ports:
- i_clk, input, 1: clock; all state updates on rising edge.
- i_rst_n, input, 1: reset; asynchronous, active-low.
- i_valid, input, 1: operand request valid.
- ready, output, 1: block can accept operands; high only in IDLE.
- i_add_term1, input, WIDTH: operand A.
- i_add_term2, input, WIDTH: operand B.
- i_cin, input, 1: carry-in.
- valid_out, output, 1: result valid; high only in DONE.
- i_ready, input, 1: consumer accepts result.
- sum, output, WIDTH: registered result.
- cout, output, 1: registered carry-out of the top chunk.

## Operation
- Chunk count N = WIDTH/6. Chunk k is bits [6k+5:6k].
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On i_valid && ready: capture both operands into internal registers, load carry_q <= i_cin, clear chunk counter k <= 0, go to RUN.
- RUN:
  - The slice sees opA[k], opB[k] and carry_q.
  - On each edge: sum[k] <= slice sum; carry_q <= slice cout; k <= k+1.
  - When k == N-1: also cout <= slice cout and go to DONE.
  - i_valid is ignored in RUN.
- DONE:
  - valid_out=1; sum and cout are held stable.
  - On i_ready: go to IDLE.
  - No operand accept in DONE; the earliest next accept is the cycle after DONE exits.
- Arithmetic: the result is modulo 2^WIDTH, with cout as the WIDTH+1th bit. Operands are unsigned.
- sum chunks not yet written in RUN hold their previous values. Consumers sample only when valid_out=1.
- Reset values, asserted asynchronously at any time including mid-RUN:
  - state=IDLE, k=0, carry_q=0, operand registers=0, sum=0, cout=0.
  - Therefore valid_out=0 and ready=1.
  - The partial operation is discarded, with no result.

## Timing
- Accept edge T0, at which IDLE->RUN.
- RUN edges are T1..TN, one chunk per edge; sum and cout are final after TN, which is the RUN->DONE edge.
- valid_out is high from TN until the edge where i_ready=1 is sampled.
- Latency from accept to valid_out: N cycles. Minimum request interval: N+2 cycles, including one IDLE cycle.
- ready and valid_out are decoded from state only. There are no combinational paths from i_valid or i_ready to any output.
- Critical path: operand mux → one 6-bit slice → carry_q. It is independent of WIDTH apart from the counter compare.

## Configuration
- CSKIPA_SEQ_SUB_EN defined:
  - An extra input i_sub (1 bit) is sampled at accept.
  - With i_sub=1, the stored opB is ~i_add_term2 and carry_q loads 1; i_cin is ignored.
  - sum = A−B mod 2^WIDTH; cout=1 means no borrow (A ≥ B).
  - With i_sub=0, behaviour is unchanged.
- CSKIPA_SEQ_SUB_EN undefined: the i_sub port is absent and the block adds only.

## Structure
- cskipa_pkg:
  - SLICE_W=6 constant.
  - State enum {IDLE, RUN, DONE}.
  - Function returning the chunk count for a WIDTH.
  - Counter width = clog2(N), minimum 1.
- Sub-module cskipa_slice6: combinational 6-bit carry-skip slice.
  - Organised as two 3-bit ripple groups.
  - Each group's carry-out is replaced by its carry-in when all group propagates are 1.
  - Ports: a[5:0], b[5:0], cin → s[5:0], co.
- The controller instantiates the slice exactly once.

## Test plan
- WIDTH=24: A=0xFFFFFF, B=0x000001, cin=0 → sum=0x000000, cout=1. valid_out is first high 4 cycles after the accept edge.
- All-propagate skip path: A=0x555555, B=0xAAAAAA, cin=1 → sum=0x000000, cout=1. With cin=0 → sum=0xFFFFFF, cout=0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → valid_out stays 1, sum/cout stable, ready=0. Pulse i_ready → IDLE next cycle, then ready=1.
- Reset mid-RUN: deassert i_rst_n after 2 RUN edges → outputs immediately 0, ready=1. The next request A=0x000123, B=0x000456 → sum=0x000579, cout=0.
- Request while busy: pulse i_valid with new operands during RUN → ignored. The result matches the first operands and no second valid_out occurs.
- With CSKIPA_SEQ_SUB_EN, i_sub=1:
  - A=0x000010, B=0x000001 → sum=0x00000F, cout=1.
  - A=0x000000, B=0x000001 → sum=0xFFFFFF, cout=0.
